digit_serial_addsub: RTL and testbench

//  Multi-cycle N-bit two's-complement adder/subtractor. Processes D bits per clock,
//  LSB digit first, through one reusable D-bit ripple slice. Trades latency for area

---
 rtl/adder_pkg.sv | 18 +
 rtl/addsub_digit.sv | 26 ++
 rtl/digit_serial_addsub.sv | 108 ++++++++++
 tb/tb_digit_serial_addsub.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared types and sizing helpers for the digit-serial adder
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } serial_state_t;

  function automatic int num_digits(input int n, input int d);
    return n / d;
  endfunction

  function automatic int cnt_width(input int num);
    return (num > 1) ? $clog2(num) : 1;
  endfunction

endpackage

// File: rtl/addsub_digit.sv
// rtl/addsub_digit.sv - combinational D-bit ripple slice, reused every digit cycle
module addsub_digit #(
  parameter int D = 4
) (
  input  logic [D-1:0] a,
  input  logic [D-1:0] b,
  input  logic         cin,
  output logic [D-1:0] s,
  output logic         cout,
  output logic         c_msb
);

  logic [D:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < D; i++) begin : g_bit
    assign s[i]     = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout  = c[D];
  // carry into the top bit of the slice, needed for signed overflow on the last digit
  assign c_msb = c[D-1];

endmodule

// File: rtl/digit_serial_addsub.sv
// rtl/digit_serial_addsub.sv - N-bit add/sub processing D bits per clock, LSB digit first
module digit_serial_addsub
  import adder_pkg::*;
#(
  parameter int N = 16,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] S,
  output logic         Cout,
  output logic         Ov
);

  localparam int NUM = num_digits(N, D);
  localparam int CW  = cnt_width(NUM);

  if (N < 2 || D < 1 || D > N || (N % D) != 0) begin : g_param_check
    $error("digit_serial_addsub: illegal N/D combination");
  end

  serial_state_t state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  a_sh;
  logic [N-1:0]  b_sh;
  logic [N-1:0]  r_sh;
  logic [N-1:0]  r_next;
  logic          carry;
  logic          sub_q;
  logic [D-1:0]  d_s;
  logic          d_cout;
  logic          d_cmsb;

  addsub_digit #(.D(D)) u_digit (
    .a     (a_sh[D-1:0]),
    .b     (b_sh[D-1:0]),
    .cin   (carry),
    .s     (d_s),
    .cout  (d_cout),
    .c_msb (d_cmsb)
  );

  // New digit enters at the top, so after NUM shifts the result is LSB-aligned
  if (D == N) begin : g_single
    assign r_next = d_s;
  end else begin : g_multi
    assign r_next = {d_s, r_sh[N-1:D]};
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      r_sh  <= '0;
      carry <= 1'b0;
      sub_q <= 1'b0;
      S     <= '0;
      Cout  <= 1'b0;
      Ov    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // subtraction as A + ~B + ~Cin, so borrow-in becomes an inverted carry-in
            a_sh  <= A;
            b_sh  <= sub ? ~B : B;
            carry <= sub ? ~Cin : Cin;
            sub_q <= sub;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> D;
          b_sh  <= b_sh >> D;
          r_sh  <= r_next;
          carry <= d_cout;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(NUM - 1)) begin
            S     <= r_next;
            Cout  <= sub_q ^ d_cout;
            Ov    <= d_cout ^ d_cmsb;
            cnt   <= '0;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_addsub.sv
// tb/tb_digit_serial_addsub.sv - directed and model-checked bench for digit_serial_addsub
module tb_digit_serial_addsub;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic       iv8, ir8, vld8, or8, cin8, sub8, co8, ovf8;
  logic [7:0] a8, b8, s8;

  digit_serial_addsub #(.N(8), .D(4)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8),
    .Cin(cin8), .sub(sub8), .out_valid(vld8), .out_ready(or8), .S(s8),
    .Cout(co8), .Ov(ovf8)
  );

  logic        iv16, or16, cin16, sub16;
  logic [15:0] a16, b16;
  logic        ir16 [3];
  logic        vld16[3];
  logic        co16 [3];
  logic        ovf16[3];
  logic [15:0] s16  [3];

  // index 0: D=1 (NUM=16), 1: D=4 (NUM=4), 2: D=16 (NUM=1)
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int DG = (g == 0) ? 1 : ((g == 1) ? 4 : 16);
    digit_serial_addsub #(.N(16), .D(DG)) u_dut (
      .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16[g]), .A(a16), .B(b16),
      .Cin(cin16), .sub(sub16), .out_valid(vld16[g]), .out_ready(or16), .S(s16[g]),
      .Cout(co16[g]), .Ov(ovf16[g])
    );
  end

  function automatic int num16(input int g);
    return (g == 0) ? 16 : ((g == 1) ? 4 : 1);
  endfunction

  task automatic op8(input string name, input logic [7:0] a, input logic [7:0] b,
                     input logic cin, input logic sb, input logic [7:0] es,
                     input logic ec, input logic eov);
    int cyc;
    @(negedge clk);
    a8 = a; b8 = b; cin8 = cin; sub8 = sb; iv8 = 1'b1;
    n_tests++;
    if (ir8 !== 1'b1) begin n_fail++; $display("FAIL %s in_ready got %b want 1", name, ir8); end
    @(negedge clk);
    iv8 = 1'b0;
    cyc = 0;
    while (vld8 !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
    n_tests++;
    if (cyc !== 2) begin n_fail++; $display("FAIL %s latency got %0d want 2", name, cyc); end
    n_tests++;
    if (s8 !== es) begin n_fail++; $display("FAIL %s S got %h want %h", name, s8, es); end
    n_tests++;
    if (co8 !== ec) begin n_fail++; $display("FAIL %s Cout got %b want %b", name, co8, ec); end
    n_tests++;
    if (ovf8 !== eov) begin n_fail++; $display("FAIL %s Ov got %b want %b", name, ovf8, eov); end
  endtask

  task automatic release8(input string name);
    @(negedge clk);
    or8 = 1'b1;
    @(negedge clk);
    or8 = 1'b0;
    n_tests++;
    if (ir8 !== 1'b1 || vld8 !== 1'b0) begin
      n_fail++; $display("FAIL %s release in_ready=%b out_valid=%b want 1/0", name, ir8, vld8);
    end
  endtask

  task automatic op16(input string name, input logic [15:0] a, input logic [15:0] b,
                      input logic cin, input logic sb);
    logic [16:0] w;
    logic [15:0] es;
    logic        ec, eov;
    int          lat[3];
    logic [15:0] hs[3];
    logic        hc[3], ho[3];
    int          cyc;
    bit          done;
    if (!sb) begin
      w   = {1'b0, a} + {1'b0, b} + 17'(cin);
      es  = w[15:0];
      eov = (a[15] == b[15]) && (es[15] != a[15]);
    end else begin
      w   = {1'b0, a} - {1'b0, b} - 17'(cin);
      es  = w[15:0];
      eov = (a[15] != b[15]) && (es[15] != a[15]);
    end
    ec = w[16];
    @(negedge clk);
    a16 = a; b16 = b; cin16 = cin; sub16 = sb; iv16 = 1'b1;
    for (int g = 0; g < 3; g++) begin
      n_tests++;
      if (ir16[g] !== 1'b1) begin n_fail++; $display("FAIL %s dut%0d in_ready got %b want 1", name, g, ir16[g]); end
      lat[g] = -1;
    end
    @(negedge clk);
    iv16 = 1'b0;
    a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom); sub16 = 1'($urandom);
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < 40) begin
      done = 1'b1;
      for (int g = 0; g < 3; g++) begin
        n_tests++;
        if (ir16[g] === 1'b1 && vld16[g] === 1'b1) begin
          n_fail++; $display("FAIL %s dut%0d in_ready and out_valid both 1", name, g);
        end
        if (vld16[g] === 1'b1 && lat[g] < 0) begin
          lat[g] = cyc; hs[g] = s16[g]; hc[g] = co16[g]; ho[g] = ovf16[g];
        end else if (lat[g] >= 0) begin
          n_tests++;
          if (vld16[g] !== 1'b1 || s16[g] !== hs[g] || co16[g] !== hc[g] || ovf16[g] !== ho[g]) begin
            n_fail++; $display("FAIL %s dut%0d hold changed S=%h want %h valid=%b", name, g, s16[g], hs[g], vld16[g]);
          end
        end
        if (lat[g] < 0) done = 1'b0;
      end
      if (!done) begin @(negedge clk); cyc++; end
    end
    for (int g = 0; g < 3; g++) begin
      n_tests++;
      if (lat[g] != num16(g)) begin n_fail++; $display("FAIL %s dut%0d latency got %0d want %0d", name, g, lat[g], num16(g)); end
      n_tests++;
      if (s16[g] !== es) begin n_fail++; $display("FAIL %s dut%0d S got %h want %h", name, g, s16[g], es); end
      n_tests++;
      if (co16[g] !== ec) begin n_fail++; $display("FAIL %s dut%0d Cout got %b want %b", name, g, co16[g], ec); end
      n_tests++;
      if (ovf16[g] !== eov) begin n_fail++; $display("FAIL %s dut%0d Ov got %b want %b", name, g, ovf16[g], eov); end
    end
    or16 = 1'b1;
    @(negedge clk);
    or16 = 1'b0;
    for (int g = 0; g < 3; g++) begin
      n_tests++;
      if (ir16[g] !== 1'b1 || vld16[g] !== 1'b0) begin
        n_fail++; $display("FAIL %s dut%0d release in_ready=%b out_valid=%b want 1/0", name, g, ir16[g], vld16[g]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (ir8 !== 1'b1 || vld8 !== 1'b0 || s8 !== 8'h00 || co8 !== 1'b0 || ovf8 !== 1'b0) begin
      n_fail++; $display("FAIL reset8 ir=%b ov=%b S=%h C=%b V=%b want 1 0 00 0 0", ir8, vld8, s8, co8, ovf8);
    end
    for (int g = 0; g < 3; g++) begin
      n_tests++;
      if (ir16[g] !== 1'b1 || vld16[g] !== 1'b0 || s16[g] !== 16'h0 || co16[g] !== 1'b0 || ovf16[g] !== 1'b0) begin
        n_fail++; $display("FAIL reset16 dut%0d ir=%b ov=%b S=%h want 1 0 0000", g, ir16[g], vld16[g], s16[g]);
      end
    end
  endtask

  task automatic test_add();
    op8("add_ovf", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    release8("add_ovf");
    op8("add_wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    release8("add_wrap");
    op8("add_cin", 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    release8("add_cin");
  endtask

  task automatic test_sub();
    op8("sub_borrow", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b1, 1'b0);
    release8("sub_borrow");
    op8("sub_ovf", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1);
    release8("sub_ovf");
    op8("sub_bin", 8'h10, 8'h05, 1'b1, 1'b1, 8'h0A, 1'b0, 1'b0);
    release8("sub_bin");
  endtask

  task automatic test_backpressure();
    op8("bp", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      iv8 = i[0]; a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
      n_tests++;
      if (vld8 !== 1'b1 || ir8 !== 1'b0 || s8 !== 8'h46 || co8 !== 1'b0 || ovf8 !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold%0d valid=%b ir=%b S=%h want 1 0 46", i, vld8, ir8, s8);
      end
    end
    // in_valid high during the HOLD->IDLE edge must not be taken
    @(negedge clk);
    iv8 = 1'b1; or8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0; or8 = 1'b0;
    n_tests++;
    if (ir8 !== 1'b1 || vld8 !== 1'b0) begin
      n_fail++; $display("FAIL bp_release ir=%b valid=%b want 1 0", ir8, vld8);
    end
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if (ir8 !== 1'b1 || vld8 !== 1'b0) begin
        n_fail++; $display("FAIL bp_no_accept ir=%b valid=%b want 1 0", ir8, vld8);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    op16("pre_reset", 16'h7000, 16'h1000, 1'b0, 1'b0);
    @(negedge clk);
    a16 = 16'h1111; b16 = 16'h2222; cin16 = 1'b0; sub16 = 1'b0; iv16 = 1'b1;
    @(negedge clk);
    iv16 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int g = 0; g < 3; g++) begin
      n_tests++;
      if (ir16[g] !== 1'b1 || vld16[g] !== 1'b0 || s16[g] !== 16'h0 || co16[g] !== 1'b0 || ovf16[g] !== 1'b0) begin
        n_fail++; $display("FAIL mid_reset dut%0d ir=%b ov=%b S=%h C=%b V=%b want 1 0 0000 0 0",
                           g, ir16[g], vld16[g], s16[g], co16[g], ovf16[g]);
      end
    end
    op16("post_reset", 16'h1234, 16'h4321, 1'b0, 1'b0);
  endtask

  task automatic test_digit_widths();
    op16("w_add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    op16("w_sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1);
    op16("w_sub_bin", 16'h0000, 16'h0000, 1'b1, 1'b1);
    op16("w_add_all", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 150; i++) begin
      op16("rand", 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    rst = 1'b1;
    iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
    iv16 = 1'b0; or16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_reset_mid_run();
    test_digit_widths();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
